sc_lane_shift_ctrl: RTL and testbench

- Upstream sequencer for one lane's background-type shift register.
- Generates the register's active-low clear and load strobes, the initial lane pattern, and periodic one-cycle shift-selection pulses.
- Shift rate is derived from the 50 MHz clock through a prescaler and a per-level period, so the lane's obstacles scroll at game speed.
- One instance per lane. It sits between the game-control FSM (start/pause/stop/level) and the lane register.

---
 rtl/sc_lane_shift_ctrl.sv | 128 ++++++++++++
 tb/tb_sc_lane_shift_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_lane_shift_ctrl.sv
// Lane shift sequencer: drives the lane register's clear/load strobes and
// emits one-cycle shift pulses at a level-dependent multiple of the prescaler.
module sc_lane_shift_ctrl #(
   parameter int DATAWIDTH      = 8,
   parameter int PRESCALE       = 2500000,
   parameter int PRESCALE_WIDTH = 22
) (
   input  logic                 SC_LANESHIFT_CLOCK_50,
   input  logic                 SC_LANESHIFT_RESET_InLow,
   input  logic                 SC_LANESHIFT_start_In,
   input  logic                 SC_LANESHIFT_pause_In,
   input  logic                 SC_LANESHIFT_stop_In,
   input  logic [2:0]           SC_LANESHIFT_level_In,
   input  logic                 SC_LANESHIFT_direction_In,
   input  logic [DATAWIDTH-1:0] SC_LANESHIFT_pattern_InBUS,
   output logic                 SC_LANESHIFT_clear_OutLow,
   output logic                 SC_LANESHIFT_load_OutLow,
   output logic [1:0]           SC_LANESHIFT_shiftselection_Out,
   output logic [DATAWIDTH-1:0] SC_LANESHIFT_data_OutBUS,
   output logic                 SC_LANESHIFT_step_OutPulse,
   output logic                 SC_LANESHIFT_running_Out
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      PAUSE = 3'd4,
      HOLD  = 3'd5
   } stateType;

   localparam logic [PRESCALE_WIDTH-1:0] prescLast = PRESCALE_WIDTH'(PRESCALE - 1);
   localparam logic [PRESCALE_WIDTH-1:0] prescOne  = PRESCALE_WIDTH'(1);

   stateType                  stateReg, stateNext;
   logic [PRESCALE_WIDTH-1:0] prescReg, prescNext;
   logic [2:0]                stepCntReg, stepCntNext;
   logic [2:0]                levelReg;
   logic                      directionReg;
   logic                      tick;
   logic                      fire;

   always_comb begin
      stateNext = stateReg;
      if (SC_LANESHIFT_start_In) begin
         stateNext = CLEAR;
      end else begin
         case (stateReg)
            IDLE:    stateNext = IDLE;
            CLEAR:   stateNext = LOAD;
            LOAD:    stateNext = RUN;
            RUN: begin
               if (SC_LANESHIFT_stop_In)       stateNext = HOLD;
               else if (SC_LANESHIFT_pause_In) stateNext = PAUSE;
            end
            PAUSE: begin
               if (SC_LANESHIFT_stop_In)        stateNext = HOLD;
               else if (!SC_LANESHIFT_pause_In) stateNext = RUN;
            end
            HOLD:    stateNext = HOLD;
            default: stateNext = IDLE;
         endcase
      end
   end

   // Counters advance on every edge that lands in RUN, so the LOAD cycle is
   // prescaler count 0 and a pulse is always registered into a RUN cycle.
   always_comb begin
      prescNext   = prescReg;
      stepCntNext = stepCntReg;
      tick        = 1'b0;
      fire        = 1'b0;
      if (stateNext == LOAD) begin
         prescNext   = '0;
         stepCntNext = '0;
      end else if (stateNext == RUN) begin
         if (prescReg == prescLast) begin
            prescNext = '0;
            tick      = 1'b1;
         end else begin
            prescNext = prescReg + prescOne;
         end
         // Period is 8-level ticks, so the last count index is 7-level = ~level.
         if (tick) begin
            if (stepCntReg == ~levelReg) begin
               stepCntNext = '0;
               fire        = 1'b1;
            end else begin
               stepCntNext = stepCntReg + 3'd1;
            end
         end
      end
   end

   always_ff @(posedge SC_LANESHIFT_CLOCK_50) begin
      if (!SC_LANESHIFT_RESET_InLow) begin
         stateReg                        <= IDLE;
         prescReg                        <= '0;
         stepCntReg                      <= '0;
         levelReg                        <= '0;
         directionReg                    <= 1'b0;
         SC_LANESHIFT_clear_OutLow       <= 1'b1;
         SC_LANESHIFT_load_OutLow        <= 1'b1;
         SC_LANESHIFT_shiftselection_Out <= 2'b00;
         SC_LANESHIFT_data_OutBUS        <= '0;
         SC_LANESHIFT_step_OutPulse      <= 1'b0;
         SC_LANESHIFT_running_Out        <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         prescReg   <= prescNext;
         stepCntReg <= stepCntNext;
         if (stateReg == CLEAR) begin
            levelReg     <= SC_LANESHIFT_level_In;
            directionReg <= SC_LANESHIFT_direction_In;
         end
         if (stateNext == LOAD) begin
            SC_LANESHIFT_data_OutBUS <= SC_LANESHIFT_pattern_InBUS;
         end
         SC_LANESHIFT_clear_OutLow       <= (stateNext != CLEAR);
         SC_LANESHIFT_load_OutLow        <= (stateNext != LOAD);
         SC_LANESHIFT_shiftselection_Out <= fire ? (directionReg ? 2'b10 : 2'b01) : 2'b00;
         SC_LANESHIFT_step_OutPulse      <= fire;
         SC_LANESHIFT_running_Out        <= (stateNext == RUN);
      end
   end

endmodule

// File: tb/tb_sc_lane_shift_ctrl.sv
// Directed bench for sc_lane_shift_ctrl with PRESCALE=4; expected output
// vectors and shift pulses are queued at drive time and checked at negedge.
module tb_sc_lane_shift_ctrl;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start, pause, stop, dir;
   logic [2:0]    level;
   logic [DW-1:0] pattern;
   logic          clearN, loadN, step, running;
   logic [1:0]    shiftSel;
   logic [DW-1:0] dataOut;

   int cyc = 0;
   int nAssert = 0;
   int nFail = 0;

   typedef struct {
      int          cyc;
      logic [13:0] v;
      string       tag;
   } expType;

   typedef struct {
      int         cyc;
      logic [1:0] code;
   } pulseType;

   expType   expQ[$];
   pulseType pulseQ[$];

   sc_lane_shift_ctrl #(
      .DATAWIDTH(DW),
      .PRESCALE(4),
      .PRESCALE_WIDTH(3)
   ) dut (
      .SC_LANESHIFT_CLOCK_50(clk),
      .SC_LANESHIFT_RESET_InLow(rstn),
      .SC_LANESHIFT_start_In(start),
      .SC_LANESHIFT_pause_In(pause),
      .SC_LANESHIFT_stop_In(stop),
      .SC_LANESHIFT_level_In(level),
      .SC_LANESHIFT_direction_In(dir),
      .SC_LANESHIFT_pattern_InBUS(pattern),
      .SC_LANESHIFT_clear_OutLow(clearN),
      .SC_LANESHIFT_load_OutLow(loadN),
      .SC_LANESHIFT_shiftselection_Out(shiftSel),
      .SC_LANESHIFT_data_OutBUS(dataOut),
      .SC_LANESHIFT_step_OutPulse(step),
      .SC_LANESHIFT_running_Out(running)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [13:0] vec(input logic c, input logic l, input logic [1:0] s,
                                       input logic st, input logic r, input logic [7:0] d);
      return {c, l, s, st, r, d};
   endfunction

   task automatic pushExp(input int c, input logic [13:0] v, input string tag);
      expType e;
      e.cyc = c; e.v = v; e.tag = tag;
      expQ.push_back(e);
   endtask

   task automatic pushPulse(input int c, input logic [1:0] code);
      pulseType p;
      p.cyc = c; p.code = code;
      pulseQ.push_back(p);
   endtask

   task automatic goTo(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: queued vector checks plus a pulse check whenever a pulse is seen or due.
   always @(negedge clk) begin
      logic [13:0] got;
      logic [2:0]  expP, gotP;
      got = {clearN, loadN, shiftSel, step, running, dataOut};
      while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
         expType e;
         e = expQ.pop_front();
         nAssert++;
         assert (got === e.v && e.cyc == cyc) else begin
            nFail++;
            $error("FAIL %s cyc=%0d (due %0d) observed=%h expected=%h", e.tag, cyc, e.cyc, got, e.v);
         end
      end
      gotP = {shiftSel, step};
      if (gotP !== 3'b000 || (pulseQ.size() > 0 && pulseQ[0].cyc == cyc)) begin
         expP = 3'b000;
         if (pulseQ.size() > 0 && pulseQ[0].cyc == cyc) begin
            pulseType p;
            p = pulseQ.pop_front();
            expP = {p.code, 1'b1};
         end
         nAssert++;
         assert (gotP === expP) else begin
            nFail++;
            $error("FAIL pulse cyc=%0d observed shift/step=%b expected=%b", cyc, gotP, expP);
         end
      end
   end

   initial begin
      int c0, c1, c2, L, L2, L3;
      rstn = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
      dir = 1'b0; level = 3'd0; pattern = '0;

      // Reset for two edges, then idle with no start.
      pushExp(2,   vec(1, 1, 2'b00, 0, 0, 8'h00), "reset");
      pushExp(3,   vec(1, 1, 2'b00, 0, 0, 8'h00), "idle_after_reset");
      pushExp(50,  vec(1, 1, 2'b00, 0, 0, 8'h00), "idle_50");
      pushExp(102, vec(1, 1, 2'b00, 0, 0, 8'h00), "idle_102");
      goTo(2);
      rstn = 1'b1;
      stop = 1'b1; pause = 1'b1;
      goTo(4);
      stop = 1'b0; pause = 1'b0;

      // Level 0, right: pulses every 32 cycles after load.
      c0 = 105;
      goTo(c0);
      pushExp(c0 + 1,  vec(0, 1, 2'b00, 0, 0, 8'h00), "A_clear");
      pushExp(c0 + 2,  vec(1, 0, 2'b00, 0, 0, 8'hF0), "A_load");
      pushExp(c0 + 3,  vec(1, 1, 2'b00, 0, 1, 8'hF0), "A_running");
      pushExp(c0 + 34, vec(1, 1, 2'b10, 1, 1, 8'hF0), "A_pulse1");
      pushExp(c0 + 35, vec(1, 1, 2'b00, 0, 1, 8'hF0), "A_pulse1_end");
      pushPulse(c0 + 34, 2'b10);
      pushPulse(c0 + 66, 2'b10);
      pushPulse(c0 + 98, 2'b10);
      level = 3'd0; dir = 1'b1; pattern = 8'hF0; start = 1'b1;
      goTo(c0 + 1);
      start = 1'b0;

      // Level 7, left, started mid-run; level change ignored; pause test.
      c1 = c0 + 100;
      L  = c1 + 2;
      goTo(c1);
      pushExp(c1 + 1, vec(0, 1, 2'b00, 0, 0, 8'hF0), "B_abort_clear");
      pushExp(L,      vec(1, 0, 2'b00, 0, 0, 8'h3C), "B_load");
      pushExp(L + 4,  vec(1, 1, 2'b01, 1, 1, 8'h3C), "B_pulse1");
      pushExp(L + 19, vec(1, 1, 2'b00, 0, 0, 8'h3C), "B_paused");
      pushExp(L + 41, vec(1, 1, 2'b00, 0, 0, 8'h3C), "B_hold");
      pushExp(L + 60, vec(1, 1, 2'b00, 0, 0, 8'h3C), "B_hold_late");
      pushPulse(L + 4,  2'b01);
      pushPulse(L + 8,  2'b01);
      pushPulse(L + 12, 2'b01);
      pushPulse(L + 16, 2'b01);
      pushPulse(L + 30, 2'b01);
      pushPulse(L + 34, 2'b01);
      pushPulse(L + 38, 2'b01);
      level = 3'd7; dir = 1'b0; pattern = 8'h3C; start = 1'b1;
      goTo(c1 + 1);
      start = 1'b0;
      goTo(c1 + 5);
      level = 3'd0; dir = 1'b1;
      goTo(L + 18);
      pause = 1'b1;
      goTo(L + 28);
      pause = 1'b0;
      goTo(L + 40);
      stop = 1'b1; pause = 1'b1;
      goTo(L + 41);
      stop = 1'b0; pause = 1'b0;

      // Restart from HOLD at level 6, then start+stop together, then reset in PAUSE.
      c2 = L + 62;
      L2 = c2 + 2;
      L3 = L2 + 20;
      goTo(c2);
      pushExp(c2 + 1,  vec(0, 1, 2'b00, 0, 0, 8'h3C), "C_clear");
      pushExp(L2,      vec(1, 0, 2'b00, 0, 0, 8'hA5), "C_load");
      pushExp(L2 + 19, vec(0, 1, 2'b00, 0, 0, 8'hA5), "C_start_stop_clear");
      pushExp(L3,      vec(1, 0, 2'b00, 0, 0, 8'hA5), "C_reload");
      pushExp(L3 + 12, vec(1, 1, 2'b00, 0, 0, 8'hA5), "C_paused");
      pushExp(L3 + 13, vec(1, 1, 2'b00, 0, 0, 8'h00), "C_reset_in_pause");
      pushExp(L3 + 44, vec(1, 1, 2'b00, 0, 0, 8'h00), "C_idle_after_reset");
      pushPulse(L2 + 8,  2'b10);
      pushPulse(L2 + 16, 2'b10);
      pushPulse(L3 + 8,  2'b10);
      level = 3'd6; dir = 1'b1; pattern = 8'hA5; start = 1'b1;
      goTo(c2 + 1);
      start = 1'b0;
      goTo(L2 + 18);
      start = 1'b1; stop = 1'b1;
      goTo(L2 + 19);
      start = 1'b0; stop = 1'b0;
      goTo(L3 + 10);
      pause = 1'b1;
      goTo(L3 + 12);
      rstn = 1'b0;
      goTo(L3 + 13);
      rstn = 1'b1; pause = 1'b0;
      goTo(L3 + 46);

      nAssert++;
      assert (pulseQ.size() == 0) else begin
         nFail++;
         $error("FAIL pulses_outstanding observed=%0d expected=0", pulseQ.size());
      end
      nAssert++;
      assert (expQ.size() == 0) else begin
         nFail++;
         $error("FAIL checks_outstanding observed=%0d expected=0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
